// File: rtl/psd_lpf_decim_if.sv
// Streaming port bundle for psd_lpf_decim: mixer product pairs in, decimated I/Q averages out.
// The slave side is the filter; the master side feeds samples and consumes results.
interface psd_lpf_decim_if #(
    parameter int IN_W = 32
);
    logic                   in_valid;
    logic signed [IN_W-1:0] data_sin_i;
    logic signed [IN_W-1:0] data_cos_i;
    logic                   out_ready;
    logic                   out_valid;
    logic signed [IN_W-1:0] i_out;
    logic signed [IN_W-1:0] q_out;

    modport master (
        output in_valid, data_sin_i, data_cos_i, out_ready,
        input  out_valid, i_out, q_out
    );

    modport slave (
        input  in_valid, data_sin_i, data_cos_i, out_ready,
        output out_valid, i_out, q_out
    );
endinterface

// File: rtl/psd_lpf_decim.sv
// Boxcar low-pass plus decimation for a PSD front end: averages 2^k mixer product pairs
// into one I/Q result held in a single-entry output buffer with a sticky overrun flag.
module psd_lpf_decim #(
    parameter int IN_W  = 32,
    parameter int ACC_W = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] dec_log2,
    input  logic       clr_ovr,
    output logic       overrun,
    psd_lpf_decim_if.slave bus
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] acc_i_p0;
    logic signed [ACC_W-1:0] acc_q_p0;
    logic [15:0]             cnt_p0;
    logic [3:0]              k_p0;

    logic signed [ACC_W-1:0] sum_i_p0;
    logic signed [ACC_W-1:0] sum_q_p0;
    logic [15:0]             last_cnt_p0;
    logic                    take_p0;
    logic                    done_p0;

    logic signed [IN_W-1:0]  i_p1;
    logic signed [IN_W-1:0]  q_p1;
    logic                    vld_p1;
    logic                    ovr_p1;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [IN_W-1:0] x);
        return {{(ACC_W-IN_W){x[IN_W-1]}}, x};
    endfunction

    // Floor division by 2^k; the window sum always fits back into IN_W after the shift.
    function automatic logic signed [IN_W-1:0] scale(input logic signed [ACC_W-1:0] s,
                                                     input logic [3:0] k);
        logic signed [ACC_W-1:0] t;
        t = s >>> k;
        return t[IN_W-1:0];
    endfunction

    // Stage p0: accumulate the current sample and detect the window's last sample
    always_comb begin
        take_p0     = (state == RUN) && en && bus.in_valid;
        sum_i_p0    = acc_i_p0 + sext(bus.data_sin_i);
        sum_q_p0    = acc_q_p0 + sext(bus.data_cos_i);
        last_cnt_p0 = (16'd1 << k_p0) - 16'd1;
        done_p0     = take_p0 && (cnt_p0 == last_cnt_p0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc_i_p0 <= '0;
            acc_q_p0 <= '0;
            cnt_p0   <= '0;
            k_p0     <= '0;
            i_p1     <= '0;
            q_p1     <= '0;
            vld_p1   <= 1'b0;
            ovr_p1   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    acc_i_p0 <= '0;
                    acc_q_p0 <= '0;
                    cnt_p0   <= '0;
                    if (en) begin
                        state <= RUN;
                        k_p0  <= dec_log2;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state    <= IDLE;
                        acc_i_p0 <= '0;
                        acc_q_p0 <= '0;
                        cnt_p0   <= '0;
                    end else if (take_p0) begin
                        if (done_p0) begin
                            acc_i_p0 <= '0;
                            acc_q_p0 <= '0;
                            cnt_p0   <= '0;
                            k_p0     <= dec_log2;
                        end else begin
                            acc_i_p0 <= sum_i_p0;
                            acc_q_p0 <= sum_q_p0;
                            cnt_p0   <= cnt_p0 + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Stage p1: output buffer keeps only the newest result
            if (done_p0) begin
                i_p1   <= scale(sum_i_p0, k_p0);
                q_p1   <= scale(sum_q_p0, k_p0);
                vld_p1 <= 1'b1;
            end else if (bus.out_ready) begin
                vld_p1 <= 1'b0;
            end

            if (done_p0 && vld_p1 && !bus.out_ready) begin
                ovr_p1 <= 1'b1;
            end else if (clr_ovr) begin
                ovr_p1 <= 1'b0;
            end
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.i_out     = i_p1;
    assign bus.q_out     = q_p1;
    assign overrun       = ovr_p1;

endmodule

// File: tb/tb_psd_lpf_decim.sv
// Bench for psd_lpf_decim: directed scenarios plus randomized traffic against a
// queue-based window-average model.
module tb_psd_lpf_decim;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] dec_log2;
    logic       clr_ovr;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    psd_lpf_decim_if #(.IN_W(32)) bus ();

    psd_lpf_decim #(.IN_W(32), .ACC_W(48)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dec_log2 (dec_log2),
        .clr_ovr  (clr_ovr),
        .overrun  (overrun),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: samples of the open window, newest result, flags
    bit          m_run;
    int          m_k;
    bit          m_valid;
    bit          m_ovr;
    logic [31:0] m_i;
    logic [31:0] m_q;
    int          sq[$];
    int          cq[$];

    task automatic model_reset();
        m_run = 0; m_k = 0; m_valid = 0; m_ovr = 0; m_i = '0; m_q = '0;
        sq.delete(); cq.delete();
    endtask

    task automatic step(input bit e, input bit v, input int s, input int c,
                        input logic [3:0] k, input bit r, input bit cl);
        bit     newr;
        bit     ovs;
        longint si;
        longint sc;
        @(negedge clk);
        en = e; bus.in_valid = v; bus.data_sin_i = s; bus.data_cos_i = c;
        dec_log2 = k; bus.out_ready = r; clr_ovr = cl;
        newr = 0; ovs = 0; si = 0; sc = 0;
        if (!m_run) begin
            sq.delete(); cq.delete();
            if (e) begin m_run = 1; m_k = int'(k); end
        end else if (!e) begin
            m_run = 0; sq.delete(); cq.delete();
        end else if (v) begin
            sq.push_back(s); cq.push_back(c);
            if (sq.size() == (1 << m_k)) begin
                foreach (sq[j]) begin si += sq[j]; sc += cq[j]; end
                si = si >>> m_k;
                sc = sc >>> m_k;
                newr = 1;
                m_k = int'(k);
                sq.delete(); cq.delete();
            end
        end
        if (newr) begin
            if (m_valid && !r) ovs = 1;
            m_valid = 1; m_i = si[31:0]; m_q = sc[31:0];
        end else if (r) begin
            m_valid = 0;
        end
        if (ovs) m_ovr = 1;
        else if (cl) m_ovr = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; en = 0; bus.in_valid = 0; bus.out_ready = 0; clr_ovr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bus.out_valid); end
        total++; if (bus.i_out !== 32'd0) begin bad++; $display("FAIL reset_i got=%0d want=0", bus.i_out); end
        total++; if (bus.q_out !== 32'd0) begin bad++; $display("FAIL reset_q got=%0d want=0", bus.q_out); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%0b want=0", overrun); end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_basic();
        do_reset();
        step(1, 0, 0, 0, 4'd2, 1, 0);
        for (int j = 0; j < 4; j++) begin
            step(1, 1, 1000, -1000, 4'd2, 1, 0);
            if (j == 2) begin
                total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_early got=%0b want=0", bus.out_valid); end
            end
        end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b want=1", bus.out_valid); end
        total++; if (bus.i_out !== 1000) begin bad++; $display("FAIL basic_i got=%0d want=1000", bus.i_out); end
        total++; if (bus.q_out !== -1000) begin bad++; $display("FAIL basic_q got=%0d want=-1000", bus.q_out); end
        step(1, 0, 0, 0, 4'd2, 1, 0);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_drop got=%0b want=0", bus.out_valid); end
    endtask

    task automatic test_floor();
        int s_tab[4] = '{-1, -1, -1, 0};
        int c_tab[4] = '{1, 1, 1, 0};
        do_reset();
        step(1, 0, 0, 0, 4'd2, 1, 0);
        for (int j = 0; j < 4; j++) step(1, 1, s_tab[j], c_tab[j], 4'd2, 1, 0);
        total++; if (bus.i_out !== -1) begin bad++; $display("FAIL floor_i got=%0d want=-1", bus.i_out); end
        total++; if (bus.q_out !== 0) begin bad++; $display("FAIL floor_q got=%0d want=0", bus.q_out); end
    endtask

    task automatic test_k15();
        int early = 0;
        do_reset();
        step(1, 0, 0, 0, 4'd15, 1, 0);
        for (int j = 0; j < 32768; j++) begin
            if (bus.out_valid) early++;
            step(1, 1, 32'h7FFFFFFF, 32'h80000000, 4'd15, 1, 0);
            if (j < 32767) begin
                if (bus.out_valid) early++;
                step(1, 0, 0, 0, 4'd15, 1, 0);
            end
        end
        total++; if (early !== 0) begin bad++; $display("FAIL k15_early got=%0d want=0", early); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL k15_valid got=%0b want=1", bus.out_valid); end
        total++; if (bus.i_out !== 32'h7FFFFFFF) begin bad++; $display("FAIL k15_i got=%0h want=7fffffff", bus.i_out); end
        total++; if (bus.q_out !== 32'h80000000) begin bad++; $display("FAIL k15_q got=%0h want=80000000", bus.q_out); end
    endtask

    task automatic test_overrun();
        do_reset();
        step(1, 0, 0, 0, 4'd0, 0, 0);
        step(1, 1, 5, 5, 4'd0, 0, 0);
        total++; if (bus.i_out !== 5 || overrun !== 1'b0) begin bad++; $display("FAIL ovr_first got i=%0d ovr=%0b want i=5 ovr=0", bus.i_out, overrun); end
        step(1, 1, 7, 7, 4'd0, 0, 0);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%0b want=1", bus.out_valid); end
        total++; if (bus.i_out !== 7) begin bad++; $display("FAIL ovr_i got=%0d want=7", bus.i_out); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%0b want=1", overrun); end
        step(1, 0, 0, 0, 4'd0, 0, 1);
        total++; if (overrun !== 1'b0 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL ovr_clr got ovr=%0b vld=%0b want ovr=0 vld=1", overrun, bus.out_valid); end
        step(1, 1, 9, 9, 4'd0, 0, 1);
        total++; if (overrun !== 1'b1 || bus.i_out !== 9) begin bad++; $display("FAIL ovr_setwins got ovr=%0b i=%0d want ovr=1 i=9", overrun, bus.i_out); end
        step(1, 0, 0, 0, 4'd0, 0, 1);
        step(1, 1, 11, 11, 4'd0, 1, 0);
        total++; if (overrun !== 1'b0 || bus.out_valid !== 1'b1 || bus.i_out !== 11) begin bad++; $display("FAIL ovr_readwrite got ovr=%0b vld=%0b i=%0d want ovr=0 vld=1 i=11", overrun, bus.out_valid, bus.i_out); end
        step(1, 0, 0, 0, 4'd0, 1, 0);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ovr_read got=%0b want=0", bus.out_valid); end
    endtask

    task automatic test_reset_midwindow();
        do_reset();
        step(1, 0, 0, 0, 4'd3, 0, 0);
        for (int j = 0; j < 8; j++) step(1, 1, 2, 2, 4'd3, 0, 0);
        for (int j = 0; j < 8; j++) step(1, 1, 3, 3, 4'd3, 0, 0);
        for (int j = 0; j < 5; j++) step(1, 1, 4, 4, 4'd3, 0, 0);
        @(negedge clk);
        rst = 1;
        #1;
        total++; if (bus.out_valid !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL rstmid_flags got vld=%0b ovr=%0b want 0 0", bus.out_valid, overrun); end
        total++; if (bus.i_out !== 0 || bus.q_out !== 0) begin bad++; $display("FAIL rstmid_data got i=%0d q=%0d want 0 0", bus.i_out, bus.q_out); end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        step(1, 0, 0, 0, 4'd3, 1, 0);
        for (int j = 0; j < 8; j++) begin
            step(1, 1, 8, 8, 4'd3, 1, 0);
            if (j == 6) begin
                total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_early got=%0b want=0", bus.out_valid); end
            end
        end
        total++; if (bus.out_valid !== 1'b1 || bus.i_out !== 8) begin bad++; $display("FAIL rstmid_result got vld=%0b i=%0d want vld=1 i=8", bus.out_valid, bus.i_out); end
    endtask

    task automatic test_en_drop();
        do_reset();
        step(1, 0, 0, 0, 4'd3, 1, 0);
        for (int j = 0; j < 3; j++) step(1, 1, 100, -100, 4'd3, 1, 0);
        step(0, 0, 0, 0, 4'd3, 1, 0);
        step(1, 0, 0, 0, 4'd3, 1, 0);
        for (int j = 1; j <= 8; j++) begin
            step(1, 1, j, -j, (j == 1) ? 4'd3 : 4'd1, 1, 0);
            if (j == 2 || j == 5) begin
                total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL endrop_early%0d got=%0b want=0", j, bus.out_valid); end
            end
        end
        total++; if (bus.out_valid !== 1'b1 || bus.i_out !== 4 || bus.q_out !== -5) begin bad++; $display("FAIL endrop_win got vld=%0b i=%0d q=%0d want 1 4 -5", bus.out_valid, bus.i_out, bus.q_out); end
        step(1, 1, 20, -20, 4'd1, 1, 0);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL endrop_half got=%0b want=0", bus.out_valid); end
        step(1, 1, 30, -30, 4'd1, 1, 0);
        total++; if (bus.out_valid !== 1'b1 || bus.i_out !== 25 || bus.q_out !== -25) begin bad++; $display("FAIL endrop_newk got vld=%0b i=%0d q=%0d want 1 25 -25", bus.out_valid, bus.i_out, bus.q_out); end
    endtask

    task automatic test_random();
        logic [3:0] kk;
        bit e, v, r, cl;
        do_reset();
        kk = 4'd1;
        for (int n = 0; n < 800; n++) begin
            e  = ($urandom_range(0, 19) != 0);
            v  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 1) != 0);
            cl = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) kk = 4'($urandom_range(0, 3));
            step(e, v, int'($urandom), int'($urandom), kk, r, cl);
            total++; if (bus.out_valid !== m_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%0b want=%0b", n, bus.out_valid, m_valid); end
            total++; if (bus.i_out !== m_i) begin bad++; $display("FAIL rnd_i cyc=%0d got=%0h want=%0h", n, bus.i_out, m_i); end
            total++; if (bus.q_out !== m_q) begin bad++; $display("FAIL rnd_q cyc=%0d got=%0h want=%0h", n, bus.q_out, m_q); end
            total++; if (overrun !== m_ovr) begin bad++; $display("FAIL rnd_ovr cyc=%0d got=%0b want=%0b", n, overrun, m_ovr); end
        end
    endtask

    initial begin
        rst = 0; en = 0; dec_log2 = '0; clr_ovr = 0;
        bus.in_valid = 0; bus.data_sin_i = '0; bus.data_cos_i = '0; bus.out_ready = 0;
        model_reset();
        test_reset();
        test_basic();
        test_floor();
        test_overrun();
        test_reset_midwindow();
        test_en_drop();
        test_random();
        test_k15();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psd_lpf_decim.md
PSD_LPF_DECIM -- requirements
Module: psd_lpf_decim

Interface
REQ-001 SHALL provide parameter IN_W, default 32, width of signed mixer products on data_sin_i/data_cos_i and of i_out/q_out.
REQ-002 SHALL provide parameter ACC_W, default 48, signed accumulator width; ACC_W SHALL be at least IN_W+15.
REQ-003 clk  input  1  single clock, all logic rising-edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  run enable; 0 forces IDLE.
REQ-006 in_valid  input  1  product pair valid this cycle.
REQ-007 data_sin_i  input  IN_W  signed in-phase product (mixer sin path).
REQ-008 data_cos_i  input  IN_W  signed quadrature product (mixer cos path).
REQ-009 dec_log2  input  4  decimation exponent k; window N = 2^k, k = 0..15.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 clr_ovr  input  1  clears overrun flag.
REQ-012 out_valid  output  1  result held in output buffer.
REQ-013 i_out  output  IN_W  signed window average of data_sin_i.
REQ-014 q_out  output  IN_W  signed window average of data_cos_i.
REQ-015 overrun  output  1  sticky: unread result was overwritten.

Function
REQ-016 FSM states SHALL be IDLE and RUN; IDLE->RUN on en=1; RUN->IDLE on en=0; no other transitions.
REQ-017 In IDLE, accumulators and sample counter SHALL be held at 0 and in_valid ignored; a partial window SHALL be discarded on RUN->IDLE.
REQ-018 In IDLE, output buffer, out_valid and overrun SHALL retain their values and the out_ready handshake SHALL keep operating.
REQ-019 k SHALL be latched on IDLE->RUN and at each window completion; mid-window dec_log2 changes SHALL take effect from the next window.
REQ-020 In RUN, each cycle with in_valid=1 SHALL add sign-extended data_sin_i/data_cos_i to the I/Q accumulators and increment the counter; in_valid=0 cycles SHALL change nothing.
REQ-021 On the cycle the Nth valid sample is accepted, the SHALL register (acc+sample)>>>k (arithmetic shift, truncation toward minus infinity, low IN_W bits) into i_out/q_out, clear accumulators and counter, and start the next window at the following sample with no sample dropped.
REQ-022 out_valid SHALL rise on the clock edge after the Nth sample is accepted (latency 1 cycle); k=0 SHALL produce one result per valid sample.
REQ-023 out_valid SHALL remain high and i_out/q_out stable until a cycle with out_ready=1, after which out_valid SHALL fall unless a new result is written in the same cycle.
REQ-024 A new result arriving while out_valid=1 and out_ready=0 SHALL overwrite the buffer with the newest result, keep out_valid=1, and set overrun.
REQ-025 A new result arriving in the same cycle as out_ready=1 SHALL load the buffer without setting overrun.
REQ-026 clr_ovr=1 SHALL clear overrun next edge; a simultaneous set SHALL win.
REQ-027 Accumulators SHALL never overflow for any input values with k<=15, given ACC_W >= IN_W+15.

Reset
REQ-028 rst=1 SHALL asynchronously force IDLE, accumulators=0, counter=0, latched k=0, i_out=0, q_out=0, out_valid=0 and overrun=0, including mid-window.
REQ-029 After rst falls, the first window SHALL start at the first valid sample accepted in RUN.

Verification
REQ-030 en=1, k=2, 4 consecutive valid samples sin=1000, cos=-1000, out_ready=1 -> out_valid high for exactly 1 cycle, 1 cycle after the 4th sample, i_out=1000, q_out=-1000.
REQ-031 k=2, sin samples -1,-1,-1,0 -> i_out=-1 (sum -3, floor shift); cos samples 1,1,1,0 -> q_out=0.
REQ-032 k=15, 32768 samples sin=0x7FFFFFFF, cos=0x80000000, in_valid toggling 1/0 -> i_out=0x7FFFFFFF, q_out=0x80000000, no wrap; gap cycles not counted.
REQ-033 k=0, out_ready=0, samples 5 then 7 -> out_valid stays 1, i_out=7, overrun=1; clr_ovr pulse -> overrun=0; out_ready pulse -> out_valid=0.
REQ-034 k=3, rst asserted after 5 samples, then 8 samples of value 8 -> all outputs 0 during reset; first result i_out=8 after the 8th post-reset sample.
REQ-035 k=3, en dropped after 3 samples, re-raised, k changed to 1 mid-window -> partial window discarded; new k applies only after the next window boundary.
